// File: rtl/fm_mod_sequencer.sv
// FM modulation sequencer: buffers signed audio samples, generates the DDS
// enable strobe from a programmable divider and computes one phase increment
// per sample, held for a programmable number of enable ticks.
module fm_mod_sequencer #(
  parameter int unsigned NBITS_SAMPLE = 16,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned HOLD_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH   = 4   // power of 2, at least 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic [31:0]                    center_inc,
  input  logic signed [NBITS_SAMPLE-1:0] kdev,
  input  logic [4:0]                     dev_shift,
  input  logic [DIV_WIDTH-1:0]           clkdiv,
  input  logic [HOLD_WIDTH-1:0]          hold_ticks,
  input  logic                           s_valid,
  input  logic signed [NBITS_SAMPLE-1:0] s_data,
  output logic                           s_ready,
  output logic                           enableclk,
  output logic [31:0]                    phaseinc,
  output logic                           running,
  output logic                           underflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = 2 * NBITS_SAMPLE;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              center_q, center_d;
  logic [NBITS_SAMPLE-1:0]  kdev_q, kdev_d;
  logic [4:0]               shift_q, shift_d;
  logic [DIV_WIDTH-1:0]     clkdiv_q, clkdiv_d, divcnt_q, divcnt_d;
  logic [HOLD_WIDTH-1:0]    hold_q, hold_d, holdcnt_q, holdcnt_d;
  logic [31:0]              phaseinc_q, phaseinc_d;
  logic                     running_q, running_d;
  logic                     underflow_q, underflow_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            cnt_q, cnt_d;
  logic [NBITS_SAMPLE-1:0]  mem_q [FIFO_DEPTH];

  logic                     full, empty, push, pop, flush, tick;
  logic [NBITS_SAMPLE-1:0]  head;
  logic signed [PW-1:0]     prod, prod_sh;
  logic [31:0]              dev_ext, calc_inc;

  assign full    = (cnt_q == LW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  // Readiness is judged on the registered level, so a pop never frees a slot
  // for a push in the same cycle.
  assign s_ready = !full && !reset;
  assign push    = s_valid && s_ready;
  assign head    = mem_q[rd_ptr_q];

  assign tick      = (state_q == StRun) && (divcnt_q == clkdiv_q);
  assign enableclk = tick && !reset;

  assign prod    = $signed({{NBITS_SAMPLE{head[NBITS_SAMPLE-1]}}, head}) *
                   $signed({{NBITS_SAMPLE{kdev_q[NBITS_SAMPLE-1]}}, kdev_q});
  assign prod_sh = prod >>> shift_q;

  if (PW >= 32) begin : g_trunc
    assign dev_ext = prod_sh[31:0];
  end else begin : g_sext
    assign dev_ext = {{(32-PW){prod_sh[PW-1]}}, prod_sh};
  end

  assign calc_inc = center_q + dev_ext;

  assign phaseinc   = phaseinc_q;
  assign running    = running_q;
  assign underflow  = underflow_q;
  assign fifo_level = cnt_q;

  // Next-state logic: FSM, divider/hold counters, phase increment and FIFO pointers.
  always_comb begin
    state_d     = state_q;
    center_d    = center_q;
    kdev_d      = kdev_q;
    shift_d     = shift_q;
    clkdiv_d    = clkdiv_q;
    hold_d      = hold_q;
    divcnt_d    = divcnt_q;
    holdcnt_d   = holdcnt_q;
    phaseinc_d  = phaseinc_q;
    underflow_d = underflow_q;
    pop         = 1'b0;
    flush       = 1'b0;

    if (stop) begin
      state_d = StIdle;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            center_d    = center_inc;
            kdev_d      = kdev;
            shift_d     = dev_shift;
            clkdiv_d    = clkdiv;
            hold_d      = hold_ticks;
            underflow_d = 1'b0;
            flush       = 1'b1;
            state_d     = StPrime;
          end
        end
        StPrime: begin
          if (!empty) begin
            pop        = 1'b1;
            phaseinc_d = calc_inc;
            divcnt_d   = '0;
            holdcnt_d  = '0;
            state_d    = StRun;
          end
        end
        StRun: begin
          divcnt_d = tick ? '0 : divcnt_q + DIV_WIDTH'(1);
          if (tick) begin
            if (holdcnt_q == hold_q) begin
              // Hold boundary: next sample, or fall back to the carrier.
              holdcnt_d = '0;
              if (!empty) begin
                pop        = 1'b1;
                phaseinc_d = calc_inc;
              end else begin
                phaseinc_d  = center_q;
                underflow_d = 1'b1;
              end
            end else begin
              holdcnt_d = holdcnt_q + HOLD_WIDTH'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);

    if (flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q + LW'(push) - LW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      center_q    <= '0;
      kdev_q      <= '0;
      shift_q     <= '0;
      clkdiv_q    <= '0;
      hold_q      <= '0;
      divcnt_q    <= '0;
      holdcnt_q   <= '0;
      phaseinc_q  <= '0;
      running_q   <= 1'b0;
      underflow_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      center_q    <= center_d;
      kdev_q      <= kdev_d;
      shift_q     <= shift_d;
      clkdiv_q    <= clkdiv_d;
      hold_q      <= hold_d;
      divcnt_q    <= divcnt_d;
      holdcnt_q   <= holdcnt_d;
      phaseinc_q  <= phaseinc_d;
      running_q   <= running_d;
      underflow_q <= underflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Sample storage; a flush discards any same-cycle push.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_fm_mod_sequencer.sv
// Scoreboard bench for fm_mod_sequencer: expected phaseinc per enable strobe
// is queued by the stimulus; a negedge monitor compares on every strobe.
module tb_fm_mod_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, stop;
  logic [31:0] center_inc;
  logic [15:0] kdev;
  logic [4:0]  dev_shift;
  logic [15:0] clkdiv, hold_ticks;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready, enableclk, running, underflow;
  logic [31:0] phaseinc;
  logic [2:0]  fifo_level;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] src_q[$];
  bit          sb_on = 1'b0;
  int          exp_period = 1;
  int          runcyc = 0;
  int          last_strobe = 0;

  always #5 clock = ~clock;

  fm_mod_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .center_inc (center_inc),
    .kdev       (kdev),
    .dev_shift  (dev_shift),
    .clkdiv     (clkdiv),
    .hold_ticks (hold_ticks),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .enableclk  (enableclk),
    .phaseinc   (phaseinc),
    .running    (running),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: on every strobe, compare phaseinc and spacing against the scoreboard.
  always @(negedge clock) begin
    if (!running) begin
      runcyc      = 0;
      last_strobe = 0;
    end else begin
      runcyc++;
    end
    if (sb_on && enableclk) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got phaseinc 0x%08h expected no strobe", phaseinc);
      end else begin
        check("phaseinc_at_strobe", phaseinc, exp_q.pop_front());
        check("strobe_gap", 32'(runcyc - last_strobe), 32'(exp_period));
      end
    end
    if (enableclk) last_strobe = runcyc;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [31:0] c, input logic [15:0] k, input logic [4:0] sh,
                     input logic [15:0] div, input logic [15:0] hold);
    center_inc = c;
    kdev       = k;
    dev_shift  = sh;
    clkdiv     = div;
    hold_ticks = hold;
    exp_period = int'(div) + 1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push_all();
    int n;
    s_valid = 1'b1;
    while (src_q.size() > 0) begin
      s_data = src_q[0];
      n = 0;
      while (!s_ready && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: got s_ready 0 expected 1");
        src_q.delete();
      end else begin
        tick();
        void'(src_q.pop_front());
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    sb_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg(32'h0, 16'h0, 5'd0, 16'd0, 16'd0);
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_enableclk", 32'(enableclk), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_phaseinc", phaseinc, 32'h0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("idle_s_ready", 32'(s_ready), 32'd1);

    // Basic modulation: 10 -> 0x10A, -10 -> 0xF6, 0 -> 0x100, two strobes each.
    cfg(32'h100, 16'd4, 5'd2, 16'd3, 16'd1);
    exp_q.push_back(32'h10A); exp_q.push_back(32'h10A);
    exp_q.push_back(32'h0F6); exp_q.push_back(32'h0F6);
    exp_q.push_back(32'h100); exp_q.push_back(32'h100);
    sb_on = 1'b1;
    pulse_start();
    src_q.push_back(16'd10); src_q.push_back(16'hFFF6); src_q.push_back(16'd0);
    push_all();
    wait_drain(200);
    check("basic_underflow", 32'(underflow), 32'd1);
    check("basic_center", phaseinc, 32'h100);
    pulse_stop();
    check("basic_stop_running", 32'(running), 32'd0);

    // Back-to-back ticks: one new sample per cycle.
    cfg(32'h1000, 16'd1, 5'd0, 16'd0, 16'd0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(32'h1000 + 32'(i));
    sb_on = 1'b1;
    pulse_start();
    for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
    push_all();
    wait_drain(100);
    pulse_stop();
    check("sticky_after_stop", 32'(underflow), 32'd1);

    // Underflow: one sample 5*2>>>1 = 5, then carrier.
    cfg(32'h2000, 16'd2, 5'd1, 16'd1, 16'd1);
    exp_q.push_back(32'h2005); exp_q.push_back(32'h2005);
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2000);
    sb_on = 1'b1;
    pulse_start();
    check("start_clears_underflow", 32'(underflow), 32'd0);
    src_q.push_back(16'd5);
    push_all();
    wait_drain(100);
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_center", phaseinc, 32'h2000);
    repeat (5) tick();
    check("uf_sticky", 32'(underflow), 32'd1);
    pulse_stop();
    pulse_start();
    check("uf_cleared", 32'(underflow), 32'd0);
    pulse_stop();

    // FIFO full in IDLE.
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 16'(8'h11 + i);
      tick();
    end
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_s_ready", 32'(s_ready), 32'd0);
    s_data = 16'h55;
    repeat (3) tick();
    check("full_refused", 32'(fifo_level), 32'd4);
    s_valid = 1'b0;
    pulse_stop();
    check("stop_flush_idle", 32'(fifo_level), 32'd0);

    // FIFO full in RUN: sixth sample waits for a pop, then lands a cycle later.
    cfg(32'h3000, 16'd1, 5'd0, 16'd3, 16'd0);
    for (int i = 1; i <= 6; i++) exp_q.push_back(32'h3000 + 32'(i));
    sb_on = 1'b1;
    pulse_start();
    s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_data = 16'(i);
      n = 0;
      while (!s_ready && n < 20) begin tick(); n++; end
      tick();
    end
    s_data = 16'd6;
    check("run_full_ready", 32'(s_ready), 32'd0);
    check("run_full_level", 32'(fifo_level), 32'd4);
    n = 0;
    while (!s_ready && n < 20) begin tick(); n++; end
    check("run_after_pop_level", 32'(fifo_level), 32'd3);
    tick();
    s_valid = 1'b0;
    check("run_refill_level", 32'(fifo_level), 32'd4);
    wait_drain(200);
    pulse_stop();

    // Stop mid-hold.
    cfg(32'h4000, 16'd1, 5'd0, 16'd2, 16'd3);
    exp_q.push_back(32'h4007); exp_q.push_back(32'h4007);
    sb_on = 1'b1;
    pulse_start();
    src_q.push_back(16'd7); src_q.push_back(16'd8); src_q.push_back(16'd9);
    push_all();
    wait_drain(100);
    check("pre_stop_level", 32'(fifo_level), 32'd2);
    pulse_stop();
    check("stop_running", 32'(running), 32'd0);
    check("stop_level", 32'(fifo_level), 32'd0);
    check("stop_phaseinc", phaseinc, 32'h4007);
    for (int i = 0; i < 4; i++) begin
      check("stop_no_strobe", 32'(enableclk), 32'd0);
      tick();
    end

    // Reset asserted on a strobe cycle.
    cfg(32'h5000, 16'd1, 5'd0, 16'd2, 16'd3);
    pulse_start();
    src_q.push_back(16'd7); src_q.push_back(16'd8); src_q.push_back(16'd9);
    push_all();
    n = 0;
    while (!enableclk && n < 50) begin tick(); n++; end
    check("pre_reset_strobe", 32'(enableclk), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_no_partial", 32'(enableclk), 32'd0);
    tick();
    check("mid_rst_phaseinc", phaseinc, 32'h0);
    check("mid_rst_running", 32'(running), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_underflow", 32'(underflow), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_enableclk", 32'(enableclk), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Wrap and sign.
    cfg(32'hFFFF_FFF0, 16'd1, 5'd0, 16'd0, 16'd0);
    exp_q.push_back(32'h0000_7FEF); exp_q.push_back(32'hFFFF_7FF0);
    sb_on = 1'b1;
    pulse_start();
    src_q.push_back(16'h7FFF); src_q.push_back(16'h8000);
    push_all();
    wait_drain(50);
    pulse_stop();

    // Full-width product with arithmetic shift (rounds toward minus infinity).
    cfg(32'h0, 16'h7FFF, 5'd16, 16'd0, 16'd0);
    exp_q.push_back(32'h0000_3FFF);
    exp_q.push_back(32'hFFFF_C000);
    exp_q.push_back(32'hFFFF_FFFF);
    sb_on = 1'b1;
    pulse_start();
    src_q.push_back(16'h7FFF); src_q.push_back(16'h8000); src_q.push_back(16'hFFFF);
    push_all();
    wait_drain(50);
    pulse_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_mod_sequencer.md
# fm_mod_sequencer

Sequencer and configuration block that drives the `dds` phase-accumulator port for FM modulation. It accepts signed audio samples over a valid/ready stream, buffers them in a small FIFO and generates the DDS `enableclk` strobe from a programmable divider. For each sample it computes `phaseinc = center_inc + ((sample * kdev) >>> dev_shift)` and holds that value for a programmable number of enable ticks. It sits between the audio source and the `dds` instance in the modulator top level.

## Interface
- `NBITS_SAMPLE`, 16, width of signed audio sample and of `kdev`
- `DIV_WIDTH`, 16, width of the enable-divider setting
- `HOLD_WIDTH`, 16, width of the per-sample hold setting
- `FIFO_DEPTH`, 4, sample FIFO entries (power of 2)
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  pulse: latch configuration, flush FIFO, clear `underflow`, begin
- `stop`  in  1  pulse: stop modulation, flush FIFO
- `center_inc`  in  32  carrier phase increment
- `kdev`  in  NBITS_SAMPLE  signed deviation gain
- `dev_shift`  in  5  arithmetic right shift applied to the product
- `clkdiv`  in  DIV_WIDTH  `enableclk` period minus 1, in clock cycles
- `hold_ticks`  in  HOLD_WIDTH  enable ticks per sample minus 1
- `s_valid`  in  1  sample valid
- `s_data`  in  NBITS_SAMPLE  signed sample
- `s_ready`  out  1  FIFO can accept
- `enableclk`  out  1  one-cycle DDS enable strobe
- `phaseinc`  out  32  DDS phase increment, registered
- `running`  out  1  high in RUN
- `underflow`  out  1  sticky: FIFO empty at a hold boundary
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- FSM states: IDLE, PRIME, RUN.
- IDLE: `start` latches `center_inc`, `kdev`, `dev_shift`, `clkdiv` and `hold_ticks`, flushes the FIFO, clears `underflow`, then goes to PRIME. The FIFO accepts samples in every state.
- PRIME: waits for FIFO not empty. It then pops the head, loads `phaseinc` from it, clears the divider and hold counters, and goes to RUN.
- RUN: the divider counter `divcnt` counts 0..clkdiv. `enableclk`=1 on the cycle where `divcnt`==clkdiv, and `divcnt` wraps to 0 on that cycle.
  - The hold counter advances on each `enableclk` and wraps after hold_ticks+1 pulses.
  - Hold boundary is the cycle carrying the last pulse of a hold. At that edge, pop the head and load `phaseinc`. If the FIFO is empty, load `center_inc` instead and set `underflow`. Ticking continues without stalling.
- `stop` (any state) goes to IDLE on the next edge, flushes the FIFO, and forces `enableclk` to 0. `phaseinc` holds its value.
- `start` in PRIME or RUN is ignored. `start` and `stop` in the same cycle: `stop` wins.
- Arithmetic:
  - Product `s_data*kdev` is a signed 2*NBITS_SAMPLE-bit value.
  - Shifted by `dev_shift` arithmetically, then sign-extended to 32 bits.
  - Added to `center_inc` modulo 2^32 with no saturation.
- FIFO: push when `s_valid && s_ready`. `s_ready` = !full && !reset and is evaluated before any same-cycle pop, so a push into a full FIFO is refused even when a pop occurs. Push and pop in the same cycle on a non-full FIFO leave `fifo_level` unchanged.

## Timing
- Reset values: IDLE, FIFO empty. `enableclk`=0, `phaseinc`=0, `running`=0, `underflow`=0, `fifo_level`=0, and `s_ready`=0 while `reset` is high. Reset mid-RUN aborts immediately with no partial strobe.
- `running` rises on the edge entering RUN and falls on the edge leaving it.
- In RUN, the first `enableclk` occurs in RUN cycle clkdiv+1, then every clkdiv+1 cycles. `clkdiv`=0 gives a strobe on every cycle.
- `phaseinc` changes only on the edge ending a boundary cycle. The DDS therefore consumes the old value with the last tick and the new value from the first tick of the next hold. This holds for all `clkdiv` values, including 0.
- One sample is consumed every (clkdiv+1)*(hold_ticks+1) cycles.

## Test plan
- Basic modulation:
  - Stimulus: `center_inc`=0x100, `kdev`=4, `dev_shift`=2, `clkdiv`=3, `hold_ticks`=1; push samples 10, -10, 0.
  - Response: `phaseinc` = 0x10A, 0xF6, 0x100; each value spans 2 strobes; strobes are 4 cycles apart.
- Back-to-back ticks:
  - Stimulus: `clkdiv`=0, `hold_ticks`=0; continuous samples 1..8.
  - Response: `enableclk` high every RUN cycle; `phaseinc` changes every cycle with no repeated or skipped sample.
- Underflow:
  - Stimulus: push one sample, run past 2 hold boundaries.
  - Response: `phaseinc`=`center_inc` after the first boundary; `underflow`=1 and stays set; a new `start` clears it.
- FIFO full:
  - Stimulus: 4 pushes in IDLE with `s_valid` held high.
  - Response: `s_ready`=0 and `fifo_level`=4; the fifth sample is not accepted until the first pop in RUN.
- Stop and reset mid-run:
  - Stimulus: `stop` mid-hold; separately, assert `reset` during RUN.
  - Response for `stop`: `enableclk`=0 from the next cycle, `fifo_level`=0, `phaseinc` unchanged.
  - Response for `reset`: all outputs at their reset values on the next cycle.
- Wrap and sign:
  - Stimulus: `center_inc`=0xFFFFFFF0, sample 0x7FFF, `kdev`=1, `dev_shift`=0.
  - Response: `phaseinc`=0x00007FEF (mod 2^32). With sample 0x8000 the response is 0xFFFF7FF0.
